// File: rtl/fifo_sc_frame_reader_if.sv
// ---------------------------------------------------------------------------
// fifo_sc_frame_reader_if
//   Bundles the three buses of the FIFO frame reader:
//     FIFO read side : fifo_read, fifo_data_out, fifo_valid_out, fifo_empty
//     Command side   : cmd_val, cmd_len, cmd_rdy
//     Stream side    : m_dat, m_val, m_last, m_rdy, plus done / err status
//   modport master : the frame reader itself
//   modport slave  : the environment (FIFO, command source, stream sink)
// ---------------------------------------------------------------------------
interface fifo_sc_frame_reader_if #(
  parameter int W  = 16,
  parameter int LW = 16
);
  logic          fifo_read;
  logic [W-1:0]  fifo_data_out;
  logic          fifo_valid_out;
  logic          fifo_empty;

  logic          cmd_val;
  logic [LW-1:0] cmd_len;
  logic          cmd_rdy;

  logic [W-1:0]  m_dat;
  logic          m_val;
  logic          m_last;
  logic          m_rdy;

  logic          done;
  logic          err;

  modport master (
    output fifo_read, cmd_rdy, m_dat, m_val, m_last, done, err,
    input  fifo_data_out, fifo_valid_out, fifo_empty, cmd_val, cmd_len, m_rdy
  );

  modport slave (
    input  fifo_read, cmd_rdy, m_dat, m_val, m_last, done, err,
    output fifo_data_out, fifo_valid_out, fifo_empty, cmd_val, cmd_len, m_rdy
  );
endinterface

// File: rtl/fifo_sc_frame_reader.sv
// ---------------------------------------------------------------------------
// fifo_sc_frame_reader
//   Read-side master for a single-clock FIFO. Accepts frame length commands,
//   reads exactly that many words from the FIFO and presents them as a
//   valid/ready stream with m_last on the final word. A 2-entry prefetch
//   buffer hides the FIFO's 1-cycle read latency so the stream runs at
//   1 word/cycle when the sink is always ready.
//
//   Ports:
//     clk, rst       : clock, synchronous active-high reset
//     bus (master)   : FIFO read strobe/data, command handshake, stream
//                      output, done pulse and sticky err flag
// ---------------------------------------------------------------------------
module fifo_sc_frame_reader #(
  parameter int W  = 16,
  parameter int LW = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  fifo_sc_frame_reader_if.master   bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t        state_q;
  logic [LW-1:0] rd_rem_q;     // words still to be read from the FIFO
  logic [LW-1:0] wr_rem_q;     // words still to be delivered downstream
  logic          cmd_rdy_q;
  logic          done_q;
  logic          err_q;
  logic          inflight_q, inflight_d;
  logic [1:0]    occ_q, occ_d;
  logic [W-1:0]  head_q, head_d;   // buffer entry presented on m_dat
  logic [W-1:0]  tail_q, tail_d;   // second buffer entry

  logic pop;
  logic wr;
  logic accept;
  logic rd_issue;

  assign pop    = (occ_q != 2'd0) & bus.m_rdy;
  assign accept = bus.cmd_val & cmd_rdy_q;
  // Returned data is only trusted when a read is outstanding.
  assign wr     = bus.fifo_valid_out & inflight_q;

  // Room check: buffered + outstanding words after this cycle's pop must stay
  // within the two buffer entries. Written as a sum comparison so nothing
  // underflows. Gated by rst so no read is launched whose data would return
  // after the reset had already cleared inflight.
  assign rd_issue = (state_q == ACTIVE) & ~bus.fifo_empty & (rd_rem_q != '0)
                  & (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}))
                  & ~rst;

  assign bus.fifo_read = rd_issue;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.m_val     = (occ_q != 2'd0);
  assign bus.m_dat     = head_q;
  assign bus.m_last    = (wr_rem_q == LW'(1)) & (occ_q != 2'd0);
  assign bus.done      = done_q;
  assign bus.err       = err_q;

  // Prefetch buffer next state. Head is always entry 0; a pop shifts the tail
  // forward, so order is preserved without pointers.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    head_d     = head_q;
    tail_d     = tail_q;
    occ_d      = occ_q;
    inflight_d = inflight_q;

    unique case ({wr, pop})
      2'b10: begin
        if (occ_q == 2'd0) head_d = bus.fifo_data_out;
        else               tail_d = bus.fifo_data_out;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new word lands behind whatever remains.
        if (occ_q == 2'd1) begin
          head_d = bus.fifo_data_out;
        end else begin
          head_d = tail_q;
          tail_d = bus.fifo_data_out;
        end
      end
      default: ;
    endcase

    // A new read overlapping the previous return keeps exactly one in flight.
    if (rd_issue)                 inflight_d = 1'b1;
    else if (bus.fifo_valid_out)  inflight_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the buffer entries are reset too, because m_dat must read 0 after reset.
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= 2'd0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      if (bus.fifo_valid_out & ~inflight_q) err_q <= 1'b1;
    end
  end

  // Frame control FSM with registered cmd_rdy / done.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q   <= IDLE;
      rd_rem_q  <= '0;
      wr_rem_q  <= '0;
      cmd_rdy_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cmd_rdy_q <= 1'b1;
          if (accept) begin
            if (bus.cmd_len != '0) begin
              state_q   <= ACTIVE;
              rd_rem_q  <= bus.cmd_len;
              wr_rem_q  <= bus.cmd_len;
              cmd_rdy_q <= 1'b0;
            end else begin
              // Empty frame: acknowledge with done, emit nothing.
              done_q <= 1'b1;
            end
          end
        end
        ACTIVE: begin
          cmd_rdy_q <= 1'b0;
          if (rd_issue) rd_rem_q <= rd_rem_q - LW'(1);
          if (pop) begin
            wr_rem_q <= wr_rem_q - LW'(1);
            if (wr_rem_q == LW'(1)) begin
              state_q   <= IDLE;
              done_q    <= 1'b1;
              cmd_rdy_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_sc_frame_reader.sv
module tb_fifo_sc_frame_reader;
  localparam int W  = 16;
  localparam int LW = 16;

  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  fifo_sc_frame_reader_if #(.W(W), .LW(LW)) bus ();

  fifo_sc_frame_reader #(.W(W), .LW(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks;
  int n_errors;
  int cyc;

  // FIFO contents and the words the stream must deliver, in order.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];

  // Frame-level reference state.
  int frame_left;
  int reads_left;
  int reads_total;
  int pops_total;
  int frame_reads;
  int last_count;
  int accept_cyc;
  int first_val_cyc;
  int last_pop_cyc;
  int rdy_mode;       // 0: always ready, 1: 1,0,0,1 pattern, 2: random, 3: never

  bit done_exp;
  bit err_exp;
  bit stalled_prev;
  bit rd_sampled;
  bit inject_spur;
  bit spur_now;
  logic [W-1:0] prev_dat;
  logic         prev_last;

  task automatic push_word(input logic [W-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  // One clock cycle: drive m_rdy, observe at the falling edge against the
  // reference model, then advance the FIFO model after the rising edge.
  task automatic clock_cycle();
    bit done_next;
    logic [W-1:0] want;
    case (rdy_mode)
      0:       bus.m_rdy = 1'b1;
      1:       bus.m_rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       bus.m_rdy = 1'($urandom_range(0, 1));
      default: bus.m_rdy = 1'b0;
    endcase
    @(negedge clk);
    rd_sampled = bus.fifo_read;
    if (!rst) begin
      done_next = 1'b0;

      n_checks++;
      if (bus.done !== done_exp) begin
        n_errors++;
        $display("FAIL done: got %b want %b at cycle %0d", bus.done, done_exp, cyc);
      end
      n_checks++;
      if (bus.err !== err_exp) begin
        n_errors++;
        $display("FAIL err: got %b want %b at cycle %0d", bus.err, err_exp, cyc);
      end
      if (stalled_prev) begin
        n_checks++;
        if (bus.m_val !== 1'b1 || bus.m_dat !== prev_dat || bus.m_last !== prev_last) begin
          n_errors++;
          $display("FAIL stall_hold: got val=%b dat=%h last=%b want val=1 dat=%h last=%b at cycle %0d",
                   bus.m_val, bus.m_dat, bus.m_last, prev_dat, prev_last, cyc);
        end
      end
      n_checks++;
      if (reads_total - pops_total > 2) begin
        n_errors++;
        $display("FAIL occupancy: got %0d words held want <= 2 at cycle %0d",
                 reads_total - pops_total, cyc);
      end

      if (bus.fifo_read === 1'b1) begin
        n_checks++;
        if (bus.fifo_empty || reads_left == 0) begin
          n_errors++;
          $display("FAIL overread: got read with empty=%b reads_left=%0d want no read at cycle %0d",
                   bus.fifo_empty, reads_left, cyc);
        end
        if (reads_left > 0) reads_left--;
        reads_total++;
        frame_reads++;
      end

      if (bus.m_val === 1'b1 && first_val_cyc < 0) first_val_cyc = cyc;
      n_checks++;
      if (bus.m_last !== (bus.m_val === 1'b1 && frame_left == 1)) begin
        n_errors++;
        $display("FAIL m_last: got %b want %b (val=%b left=%0d) at cycle %0d",
                 bus.m_last, (bus.m_val === 1'b1 && frame_left == 1), bus.m_val, frame_left, cyc);
      end

      if (bus.m_val === 1'b1 && bus.m_rdy) begin
        n_checks++;
        if (exp_q.size() == 0 || frame_left == 0) begin
          n_errors++;
          $display("FAIL extra_word: got %h want no transfer at cycle %0d", bus.m_dat, cyc);
        end else begin
          want = exp_q.pop_front();
          if (bus.m_dat !== want) begin
            n_errors++;
            $display("FAIL m_dat: got %h want %h at cycle %0d", bus.m_dat, want, cyc);
          end
          frame_left--;
          if (frame_left == 0) done_next = 1'b1;
        end
        pops_total++;
        last_pop_cyc = cyc;
        if (bus.m_last === 1'b1) last_count++;
      end

      if (bus.cmd_val && bus.cmd_rdy === 1'b1) begin
        n_checks++;
        if (frame_left != 0) begin
          n_errors++;
          $display("FAIL cmd_rdy: got accept with %0d words pending want 0 at cycle %0d",
                   frame_left, cyc);
        end
        accept_cyc    = cyc;
        first_val_cyc = -1;
        frame_reads   = 0;
        if (bus.cmd_len == '0) begin
          done_next = 1'b1;
        end else begin
          frame_left = int'(bus.cmd_len);
          reads_left = int'(bus.cmd_len);
        end
      end

      stalled_prev = (bus.m_val === 1'b1) && !bus.m_rdy;
      prev_dat     = bus.m_dat;
      prev_last    = bus.m_last;
      done_exp     = done_next;
      err_exp      = err_exp | spur_now;
    end
    @(posedge clk);
    #1;
    spur_now = 1'b0;
    if (rd_sampled && fifo_q.size() > 0) begin
      bus.fifo_data_out  = fifo_q.pop_front();
      bus.fifo_valid_out = 1'b1;
    end else if (inject_spur) begin
      bus.fifo_data_out  = W'($urandom);
      bus.fifo_valid_out = 1'b1;
      spur_now           = 1'b1;
      inject_spur        = 1'b0;
    end else begin
      bus.fifo_data_out  = W'($urandom);
      bus.fifo_valid_out = 1'b0;
    end
    bus.fifo_empty = (fifo_q.size() == 0);
    cyc++;
  endtask

  task automatic reset_edge();
    rst = 1'b1;
    clock_cycle();
  endtask

  task automatic reset_release();
    clock_cycle();
    rst          = 1'b0;
    exp_q        = fifo_q;
    frame_left   = 0;
    reads_left   = 0;
    reads_total  = 0;
    pops_total   = 0;
    done_exp     = 1'b0;
    err_exp      = 1'b0;
    stalled_prev = 1'b0;
  endtask

  task automatic send_cmd(input int len);
    int t = 0;
    while (bus.cmd_rdy !== 1'b1 && t < 50) begin
      clock_cycle();
      t++;
    end
    if (bus.cmd_rdy !== 1'b1) begin
      n_checks++;
      n_errors++;
      $display("FAIL cmd_wait: got cmd_rdy=%b want 1 within 50 cycles", bus.cmd_rdy);
    end
    bus.cmd_val = 1'b1;
    bus.cmd_len = LW'(len);
    clock_cycle();
    bus.cmd_val = 1'b0;
    bus.cmd_len = LW'($urandom);
  endtask

  task automatic wait_idle(input int max_cycles);
    int t = 0;
    while ((frame_left != 0 || done_exp) && t < max_cycles) begin
      clock_cycle();
      t++;
    end
    if (frame_left != 0 || done_exp) begin
      n_checks++;
      n_errors++;
      $display("FAIL frame_timeout: got %0d words pending want 0 after %0d cycles", frame_left, max_cycles);
    end
  endtask

  task automatic test_reset();
    reset_edge();
    n_checks++;
    if ({bus.fifo_read, bus.cmd_rdy, bus.m_val, bus.m_last, bus.done, bus.err, bus.m_dat} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rd=%b rdy=%b val=%b last=%b done=%b err=%b dat=%h want all 0",
               bus.fifo_read, bus.cmd_rdy, bus.m_val, bus.m_last, bus.done, bus.err, bus.m_dat);
    end
    reset_release();
    clock_cycle();
    n_checks++;
    if (bus.cmd_rdy !== 1'b1 || bus.m_val !== 1'b0) begin
      n_errors++;
      $display("FAIL idle_after_reset: got rdy=%b val=%b want rdy=1 val=0", bus.cmd_rdy, bus.m_val);
    end
  endtask

  task automatic test_single_frame();
    int lc0 = last_count;
    rdy_mode = 0;
    for (int i = 1; i <= 8; i++) push_word(W'(i));
    send_cmd(8);
    wait_idle(40);
    n_checks++;
    if (first_val_cyc != accept_cyc + 3) begin
      n_errors++;
      $display("FAIL latency: got first m_val %0d cycles after accept want 3", first_val_cyc - accept_cyc);
    end
    n_checks++;
    if (last_pop_cyc - first_val_cyc != 7) begin
      n_errors++;
      $display("FAIL throughput: got 8 words over %0d cycles want 8", last_pop_cyc - first_val_cyc + 1);
    end
    n_checks++;
    if (frame_reads != 8) begin
      n_errors++;
      $display("FAIL read_count: got %0d want 8", frame_reads);
    end
    n_checks++;
    if (last_count - lc0 != 1 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL frame8_end: got lasts=%0d left=%0d want lasts=1 left=0", last_count - lc0, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int lc0 = last_count;
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) push_word(W'($urandom));
    send_cmd(4);
    wait_idle(30);
    n_checks++;
    if (frame_reads != 4 || fifo_q.size() != 6) begin
      n_errors++;
      $display("FAIL first_frame_reads: got reads=%0d fifo_left=%0d want 4 and 6", frame_reads, fifo_q.size());
    end
    send_cmd(6);
    wait_idle(30);
    n_checks++;
    if (frame_reads != 6 || last_count - lc0 != 2 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL second_frame: got reads=%0d lasts=%0d left=%0d want 6, 2, 0",
               frame_reads, last_count - lc0, exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    int lc0 = last_count;
    int len;
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) push_word(W'($urandom));
    send_cmd(5);
    wait_idle(100);
    n_checks++;
    if (last_count - lc0 != 1 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL pattern_stall: got lasts=%0d left=%0d want 1 and 0", last_count - lc0, exp_q.size());
    end
    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 9);
      for (int i = 0; i < len; i++) push_word(W'($urandom));
      send_cmd(len);
      wait_idle(200);
    end
    n_checks++;
    if (last_count - lc0 != 7 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL random_stall: got lasts=%0d left=%0d want 7 and 0", last_count - lc0, exp_q.size());
    end
  endtask

  task automatic test_fifo_gap();
    int lc0 = last_count;
    int p0  = pops_total;
    int t   = 0;
    rdy_mode = 0;
    push_word(W'($urandom));
    push_word(W'($urandom));
    send_cmd(6);
    while (pops_total - p0 < 2 && t < 20) begin
      clock_cycle();
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (bus.m_val !== 1'b0) begin
        n_errors++;
        $display("FAIL gap_m_val: got %b want 0 at gap cycle %0d", bus.m_val, i);
      end
      clock_cycle();
    end
    for (int i = 0; i < 4; i++) push_word(W'($urandom));
    wait_idle(40);
    n_checks++;
    if (frame_reads != 6 || last_count - lc0 != 1 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL gap_frame: got reads=%0d lasts=%0d left=%0d want 6, 1, 0",
               frame_reads, last_count - lc0, exp_q.size());
    end
  endtask

  task automatic test_zero_len();
    int lc0 = last_count;
    rdy_mode = 0;
    send_cmd(0);
    n_checks++;
    if (bus.done !== 1'b1 || bus.m_val !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_len: got done=%b val=%b want done=1 val=0", bus.done, bus.m_val);
    end
    clock_cycle();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_errors++;
      $display("FAIL zero_len_pulse: got done=%b want 0", bus.done);
    end
    push_word(W'($urandom));
    send_cmd(1);
    wait_idle(20);
    n_checks++;
    if (last_count - lc0 != 1 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL one_word: got lasts=%0d left=%0d want 1 and 0", last_count - lc0, exp_q.size());
    end
  endtask

  task automatic test_reset_inflight();
    int r0;
    int lc0;
    int t = 0;
    rdy_mode = 3;
    for (int i = 0; i < 5; i++) push_word(W'($urandom));
    send_cmd(5);
    r0 = reads_total;
    while (reads_total - r0 < 2 && t < 20) begin
      clock_cycle();
      t++;
    end
    reset_edge();
    n_checks++;
    if ({bus.fifo_read, bus.cmd_rdy, bus.m_val, bus.m_last, bus.done, bus.err, bus.m_dat} !== '0) begin
      n_errors++;
      $display("FAIL reset_busy: got rd=%b rdy=%b val=%b last=%b done=%b err=%b dat=%h want all 0",
               bus.fifo_read, bus.cmd_rdy, bus.m_val, bus.m_last, bus.done, bus.err, bus.m_dat);
    end
    reset_release();
    lc0 = last_count;
    rdy_mode = 0;
    send_cmd(3);
    wait_idle(30);
    n_checks++;
    if (frame_reads != 3 || last_count - lc0 != 1 || exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL fresh_frame: got reads=%0d lasts=%0d left=%0d want 3, 1, 0",
               frame_reads, last_count - lc0, exp_q.size());
    end
  endtask

  task automatic test_spurious_err();
    rdy_mode = 0;
    clock_cycle();
    inject_spur = 1'b1;
    clock_cycle();
    clock_cycle();
    n_checks++;
    if (bus.err !== 1'b1 || bus.m_val !== 1'b0) begin
      n_errors++;
      $display("FAIL spurious: got err=%b val=%b want err=1 val=0", bus.err, bus.m_val);
    end
    push_word(W'($urandom));
    push_word(W'($urandom));
    send_cmd(2);
    wait_idle(20);
    n_checks++;
    if (bus.err !== 1'b1) begin
      n_errors++;
      $display("FAIL err_sticky: got %b want 1", bus.err);
    end
    reset_edge();
    n_checks++;
    if (bus.err !== 1'b0) begin
      n_errors++;
      $display("FAIL err_reset: got %b want 0", bus.err);
    end
    reset_release();
  endtask

  initial begin
    n_checks           = 0;
    n_errors           = 0;
    cyc                = 0;
    rst                = 1'b1;
    rdy_mode           = 0;
    frame_left         = 0;
    reads_left         = 0;
    reads_total        = 0;
    pops_total         = 0;
    frame_reads        = 0;
    last_count         = 0;
    accept_cyc         = 0;
    first_val_cyc      = -1;
    last_pop_cyc       = 0;
    done_exp           = 1'b0;
    err_exp            = 1'b0;
    stalled_prev       = 1'b0;
    inject_spur        = 1'b0;
    spur_now           = 1'b0;
    bus.cmd_val        = 1'b0;
    bus.cmd_len        = '0;
    bus.m_rdy          = 1'b1;
    bus.fifo_valid_out = 1'b0;
    bus.fifo_data_out  = '0;
    bus.fifo_empty     = 1'b1;

    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_fifo_gap();
    test_zero_len();
    test_reset_inflight();
    test_spurious_err();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
